// File: rtl/uart_tx_16bit_pkg.sv
// uart_tx_16bit_pkg
// Shared definitions for the 16-bit UART transmit path.
// Holds the default baud divisor so the matching receiver and this transmitter
// agree on bit timing, plus the state encodings of the byte serialiser and the
// word sequencer.
package uart_tx_16bit_pkg;

    // Clock cycles per UART bit (baud = f_clk / DEFAULT_CLKS_PER_BIT)
    localparam int DEFAULT_CLKS_PER_BIT = 1250;

    // Byte serialiser: one 8N1 frame per request
    typedef enum logic [1:0] {
        BYTE_IDLE  = 2'd0,
        BYTE_START = 2'd1,
        BYTE_DATA  = 2'd2,
        BYTE_STOP  = 2'd3
    } byteState_e;

    // Word sequencer: high byte frame, then low byte frame
    typedef enum logic [2:0] {
        WORD_IDLE    = 3'd0,
        WORD_SEND_HI = 3'd1,
        WORD_WAIT_HI = 3'd2,
        WORD_SEND_LO = 3'd3,
        WORD_WAIT_LO = 3'd4,
        WORD_DONE    = 3'd5
    } wordState_e;

endpackage

// File: rtl/uart_tx.sv
// uart_tx
// Byte serialiser: sends one 8N1 frame (start 0, 8 data bits LSB first, stop 1),
// each bit lasting exactly CLKS_PER_BIT clock cycles.
// Ports:
//   i_clk       system clock, rising edge
//   i_rst       asynchronous active-high reset
//   i_txdv      1-cycle request; i_txbyte is captured when idle
//   i_txbyte    byte to send
//   o_uarttx    serial line, registered, idles high
//   o_txactive  high while a frame is in progress
//   o_txdone    1-cycle pulse during the last cycle of the stop bit
module uart_tx
    import uart_tx_16bit_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_txdv,
    input  logic [7:0] i_txbyte,
    output logic       o_uarttx,
    output logic       o_txactive,
    output logic       o_txdone
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    byteState_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bitEnd;

    assign bitEnd = (cnt_q == LAST_CNT);

    // The line value for the next bit is computed here and registered, so the
    // pin only ever changes on a clock edge. The shift register always holds the
    // remaining data bits with the current one at bit 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        case (state_q)
            BYTE_IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (i_txdv) begin
                    shift_d = i_txbyte;
                    tx_d    = 1'b0;
                    state_d = BYTE_START;
                end
            end
            BYTE_START: begin
                if (bitEnd) begin
                    cnt_d    = '0;
                    bitIdx_d = 3'd0;
                    tx_d     = shift_q[0];
                    state_d  = BYTE_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYTE_DATA: begin
                if (bitEnd) begin
                    cnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = BYTE_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        tx_d     = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYTE_STOP: begin
                if (bitEnd) begin
                    cnt_d   = '0;
                    state_d = BYTE_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = BYTE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= BYTE_IDLE;
            cnt_q    <= '0;
            bitIdx_q <= 3'd0;
            shift_q  <= 8'h00;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

    assign o_uarttx   = tx_q;
    assign o_txactive = (state_q != BYTE_IDLE);
    // Pulses in the final stop-bit cycle so the word sequencer can issue the
    // next request with only a single idle-high cycle between frames.
    assign o_txdone   = (state_q == BYTE_STOP) && bitEnd;

endmodule

// File: rtl/uart_tx_16bit.sv
// uart_tx_16bit
// Sends a 16-bit word as two 8N1 frames, high byte first, separated by one
// idle-high cycle. The word is captured on accept, so i_data may change freely
// while the frames are on the line.
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_datavalid  word strobe, taken only while o_ready=1
//   i_data       {high byte, low byte}
//   o_ready      idle (or finishing) and able to accept a word this cycle
//   o_uarttx     serial line, idles high
//   o_busy       high from the cycle after accept through the o_done cycle
//   o_done       1-cycle pulse after the low-byte stop bit
module uart_tx_16bit
    import uart_tx_16bit_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_datavalid,
    input  logic [15:0] i_data,
    output logic        o_ready,
    output logic        o_uarttx,
    output logic        o_busy,
    output logic        o_done
);

    wordState_e  state_q, state_d;
    logic [15:0] data_q, data_d;
    logic        accept;
    logic        txDv;
    logic [7:0]  txByte;
    logic        txActive;
    logic        txDone;

    // DONE also counts as ready so a new word can follow without an extra idle cycle.
    assign o_ready = (state_q == WORD_IDLE) || (state_q == WORD_DONE);
    assign accept  = i_datavalid && o_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        txDv    = 1'b0;
        txByte  = data_q[7:0];
        case (state_q)
            WORD_IDLE: begin
                if (accept) begin
                    data_d  = i_data;
                    state_d = WORD_SEND_HI;
                end
            end
            WORD_SEND_HI: begin
                txDv    = 1'b1;
                txByte  = data_q[15:8];
                state_d = WORD_WAIT_HI;
            end
            WORD_WAIT_HI: begin
                if (txDone) begin
                    state_d = WORD_SEND_LO;
                end
            end
            WORD_SEND_LO: begin
                txDv    = 1'b1;
                txByte  = data_q[7:0];
                state_d = WORD_WAIT_LO;
            end
            WORD_WAIT_LO: begin
                if (txDone) begin
                    state_d = WORD_DONE;
                end
            end
            WORD_DONE: begin
                if (accept) begin
                    data_d  = i_data;
                    state_d = WORD_SEND_HI;
                end else begin
                    state_d = WORD_IDLE;
                end
            end
            default: begin
                state_d = WORD_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= WORD_IDLE;
            data_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_txdv     (txDv),
        .i_txbyte   (txByte),
        .o_uarttx   (o_uarttx),
        .o_txactive (txActive),
        .o_txdone   (txDone)
    );

    assign o_busy = (state_q != WORD_IDLE) || txActive;
    assign o_done = (state_q == WORD_DONE);

endmodule

// File: tb/tb_uart_tx_16bit.sv
// tb_uart_tx_16bit
// Drives two transmitters (4 and 5 clocks per bit). Expected line/status values
// come from a per-cycle frame-timing model, and an independent mid-bit sampling
// receiver pairs bytes back into words for comparison against the sent words.
module tb_uart_tx_16bit;

    localparam int C_A = 4;
    localparam int C_B = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        dv4, dv5;
    logic [15:0] data4, data5;
    logic        ready4, tx4, busy4, done4;
    logic        ready5, tx5, busy5, done5;

    int checks   = 0;
    int failures = 0;

    logic [15:0] expQ4[$];
    logic [15:0] expQ5[$];
    logic [15:0] rxQ4[$];
    logic [15:0] rxQ5[$];
    int          frameErr[2];
    bit          haveHi[2];
    logic [7:0]  hiByte[2];

    always #5 clk = ~clk;

    uart_tx_16bit #(.CLKS_PER_BIT(C_A)) dut4 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_datavalid (dv4),
        .i_data      (data4),
        .o_ready     (ready4),
        .o_uarttx    (tx4),
        .o_busy      (busy4),
        .o_done      (done4)
    );

    uart_tx_16bit #(.CLKS_PER_BIT(C_B)) dut5 (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_datavalid (dv5),
        .i_data      (data5),
        .o_ready     (ready5),
        .o_uarttx    (tx5),
        .o_busy      (busy5),
        .o_done      (done5)
    );

    function automatic logic obsLine(input int c);
        return (c == C_A) ? tx4 : tx5;
    endfunction

    // {line, ready, busy, done}
    function automatic logic [3:0] obsVec(input int c);
        return (c == C_A) ? {tx4, ready4, busy4, done4} : {tx5, ready5, busy5, done5};
    endfunction

    // Bit i of an 8N1 frame: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic frameBit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    // Expected {line, ready, busy, done} k cycles after the accept edge.
    // Line goes low one edge after accept; high frame takes 10c cycles, one idle
    // cycle, low frame 10c cycles, then the done cycle.
    function automatic logic [3:0] expVec(input logic [15:0] w, input int c, input int k);
        int   t;
        logic line;
        if (k == 0) return 4'b1010;
        t = k - 1;
        if (t < 10 * c)              line = frameBit(w[15:8], t / c);
        else if (t == 10 * c)        line = 1'b1;
        else if (t < 20 * c + 1)     line = frameBit(w[7:0], (t - 10 * c - 1) / c);
        else                         line = 1'b1;
        if (t == 20 * c + 1) return {line, 1'b1, 1'b1, 1'b1};
        return {line, 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setDrive(input int c, input logic v, input logic [15:0] d);
        if (c == C_A) begin
            dv4   = v;
            data4 = d;
        end else begin
            dv5   = v;
            data5 = d;
        end
    endtask

    // Presents a word on the next falling edge and returns at the accept edge.
    task automatic applyStimulus(input int c, input logic [15:0] w, input bit expectRx);
        logic [3:0] v;
        @(negedge clk);
        v = obsVec(c);
        checkOutput($sformatf("ready_c%0d_before_%04h", c, w), 32'(v[2]), 32'd1);
        setDrive(c, 1'b1, w);
        if (expectRx) begin
            if (c == C_A) expQ4.push_back(w);
            else          expQ5.push_back(w);
        end
        @(posedge clk);
    endtask

    // Compares every cycle from the accept edge up to lastK against the model.
    // After accept the data bus is scrambled (or replaced by the next word when
    // holdNext) to show the frames use only the captured value.
    task automatic checkWord(input int c, input logic [15:0] w, input int lastK,
                             input int pulseAt, input bit holdNext, input logic [15:0] nextWord);
        for (int k = 0; k <= lastK; k++) begin
            @(negedge clk);
            checkOutput($sformatf("c%0d_w%04h_k%0d", c, w, k), 32'(obsVec(c)), 32'(expVec(w, c, k)));
            if (k == 0) begin
                if (holdNext) setDrive(c, 1'b1, nextWord);
                else          setDrive(c, 1'b0, ~w);
            end
            if (pulseAt >= 0 && k == pulseAt)     setDrive(c, 1'b1, 16'hBEEF);
            if (pulseAt >= 0 && k == pulseAt + 1) setDrive(c, 1'b0, 16'hBEEF);
            if (k < lastK) @(posedge clk);
        end
    endtask

    // Mid-bit sampling receiver; bytes pair up high-then-low into words.
    // A reset seen anywhere abandons the frame and any half-received word.
    task automatic rxMonitor(input int c);
        int         idx = (c == C_A) ? 0 : 1;
        logic [7:0] b;
        bit         ok;
        bit         aborted;
        logic       v;
        forever begin
            @(negedge clk);
            if (rst) begin
                haveHi[idx] = 1'b0;
                continue;
            end
            if (obsLine(c) !== 1'b0) continue;
            ok      = 1'b1;
            aborted = 1'b0;
            b       = 8'h00;
            for (int i = 0; i < 10; i++) begin
                repeat ((i == 0) ? (c / 2) : c) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                end
                if (aborted) break;
                v = obsLine(c);
                if (i == 0 && v !== 1'b0) ok = 1'b0;
                else if (i == 9 && v !== 1'b1) ok = 1'b0;
                else if (i >= 1 && i <= 8) b[i-1] = v;
            end
            if (aborted) begin
                haveHi[idx] = 1'b0;
                continue;
            end
            if (!ok) frameErr[idx]++;
            if (!haveHi[idx]) begin
                hiByte[idx] = b;
                haveHi[idx] = 1'b1;
            end else begin
                if (idx == 0) rxQ4.push_back({hiByte[idx], b});
                else          rxQ5.push_back({hiByte[idx], b});
                haveHi[idx] = 1'b0;
            end
        end
    endtask

    task automatic randomRun(input int c, input int n);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = 16'($urandom());
            applyStimulus(c, w, 1'b1);
            checkWord(c, w, 20 * c + 2, -1, 1'b0, 16'h0000);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial rxMonitor(C_A);
    initial rxMonitor(C_B);

    initial begin
        rst   = 1'b0;
        dv4   = 1'b0;
        dv5   = 1'b0;
        data4 = 16'h0000;
        data5 = 16'h0000;
        frameErr[0] = 0;
        frameErr[1] = 0;
        #1 rst = 1'b1;

        $display("[TB] reset held with toggling inputs");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_c4_%0d", i), 32'(obsVec(C_A)), 32'h0000_000C);
            checkOutput($sformatf("reset_c5_%0d", i), 32'(obsVec(C_B)), 32'h0000_000C);
            setDrive(C_A, 1'($urandom()), 16'($urandom()));
            setDrive(C_B, 1'($urandom()), 16'($urandom()));
        end
        @(negedge clk);
        setDrive(C_A, 1'b0, 16'h0000);
        setDrive(C_B, 1'b0, 16'h0000);
        rst = 1'b0;

        $display("[TB] single word 0xA55A");
        applyStimulus(C_A, 16'hA55A, 1'b1);
        checkWord(C_A, 16'hA55A, 20 * C_A + 2, -1, 1'b0, 16'h0000);

        $display("[TB] back-to-back 0x00FF then 0x1234");
        applyStimulus(C_A, 16'h00FF, 1'b1);
        checkWord(C_A, 16'h00FF, 20 * C_A + 2, -1, 1'b1, 16'h1234);
        expQ4.push_back(16'h1234);
        @(posedge clk);
        checkWord(C_A, 16'h1234, 20 * C_A + 2, -1, 1'b0, 16'h0000);

        $display("[TB] strobe while busy is ignored");
        applyStimulus(C_A, 16'hC3A5, 1'b1);
        checkWord(C_A, 16'hC3A5, 20 * C_A + 2, 10, 1'b0, 16'h0000);
        for (int i = 0; i < 3 * C_A; i++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_after_ignore_%0d", i), 32'(obsVec(C_A)), 32'h0000_000C);
        end

        $display("[TB] reset during low-byte data bit");
        applyStimulus(C_A, 16'h9356, 1'b0);
        checkWord(C_A, 16'h9356, 11 * C_A + 3, -1, 1'b0, 16'h0000);
        rst = 1'b1;
        #1;
        checkOutput("reset_async_line", 32'(obsVec(C_A)), 32'h0000_000C);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput($sformatf("reset_mid_hold_%0d", i), 32'(obsVec(C_A)), 32'h0000_000C);
        end
        rst = 1'b0;
        applyStimulus(C_A, 16'h0001, 1'b1);
        checkWord(C_A, 16'h0001, 20 * C_A + 2, -1, 1'b0, 16'h0000);

        $display("[TB] random loopback at 4 and 5 clocks per bit");
        fork
            randomRun(C_A, 256);
            randomRun(C_B, 256);
        join

        repeat (20) @(negedge clk);
        checkOutput("rx4_count", 32'(rxQ4.size()), 32'(expQ4.size()));
        checkOutput("rx5_count", 32'(rxQ5.size()), 32'(expQ5.size()));
        for (int i = 0; i < expQ4.size() && i < rxQ4.size(); i++)
            checkOutput($sformatf("rx4_word_%0d", i), 32'(rxQ4[i]), 32'(expQ4[i]));
        for (int i = 0; i < expQ5.size() && i < rxQ5.size(); i++)
            checkOutput($sformatf("rx5_word_%0d", i), 32'(rxQ5[i]), 32'(expQ5[i]));
        checkOutput("rx4_framing", 32'(frameErr[0]), 32'd0);
        checkOutput("rx5_framing", 32'(frameErr[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
